// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI master (mode 0) exchanging record bits from a 16-bit start offset downward
module spi_controller #(
  parameter int SYSCLK_MHZ = 27,
  parameter int SCK_DIV    = 4,
  parameter int REC_BITS   = 2048,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2
) (
  input  logic                sysclock,
  input  logic                sysreset_n,
  input  logic                start,
  input  logic [15:0]         offset,
  input  logic [15:0]         nbits,
  input  logic [REC_BITS-1:0] tx_data,
  output logic [REC_BITS-1:0] rx_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                sck,
  output logic                ss,
  output logic                copi,
  input  logic                cipo
);

  localparam int          IW         = (REC_BITS > 1) ? $clog2(REC_BITS) : 1;
  localparam logic [15:0] DIV_LAST   = 16'(SCK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(SS_HOLD - 1);

  if (SYSCLK_MHZ < 1 || SCK_DIV < 1 || SS_SETUP < 1 || SS_HOLD < 1 ||
      REC_BITS < 1 || REC_BITS > 65536) begin : g_bad_params
    $error("spi_controller: invalid parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_OFS, S_XCHG, S_HOLD, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   off_q, off_d;
  logic [IW-1:0] idx_q, idx_d, idx_m1;
  logic [16:0]   rem_q, rem_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic          echo_q, echo_d;
  logic          sck_q, sck_d, ss_q, ss_d, copi_q, copi_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [REC_BITS-1:0] rx_q;
  logic          rx_we;
  logic [16:0]   lim, len;
  logic          reject;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    echo_d  = echo_q;
    sck_d   = sck_q;
    ss_d    = ss_q;
    copi_d  = copi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rx_we   = 1'b0;
    idx_m1  = idx_q - 1'b1;
    // Clamp so the descending index stops at bit 0 instead of wrapping.
    lim     = {1'b0, offset} + 17'd1;
    len     = ({1'b0, nbits} < lim) ? {1'b0, nbits} : lim;
    reject  = ({16'd0, offset} >= 32'(REC_BITS)) || (nbits == 16'd0);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (reject) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_SETUP;
            ss_d    = 1'b0;
            off_d   = offset;
            idx_d   = offset[IW-1:0];
            rem_d   = len;
            copi_d  = offset[15];
            cnt_d   = SETUP_LAST;
            div_d   = 16'd0;
            bit_d   = 4'd0;
            echo_d  = 1'b0;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == 16'd0) state_d = S_OFS;
        else cnt_d = cnt_q - 16'd1;
      end
      S_OFS, S_XCHG: begin
        if (div_q == DIV_LAST) begin
          div_d = 16'd0;
          sck_d = ~sck_q;
          // End of high phase: sample cipo and present the next copi bit.
          if (sck_q) begin
            if (state_q == S_OFS) begin
              if (bit_q != 4'd0 && cipo != off_q[4'd0 - bit_q]) echo_d = 1'b1;
              bit_d = bit_q + 4'd1;
              if (bit_q == 4'd15) begin
                state_d = S_XCHG;
                copi_d  = tx_data[idx_q];
              end else begin
                copi_d = off_q[4'd14 - bit_q];
              end
            end else begin
              rx_we = 1'b1;
              if (rem_q == 17'd1) begin
                state_d = S_HOLD;
                cnt_d   = HOLD_LAST;
                copi_d  = 1'b0;
              end else begin
                rem_d  = rem_q - 17'd1;
                idx_d  = idx_m1;
                copi_d = tx_data[idx_m1];
              end
            end
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 16'd0) state_d = S_DONE;
        else cnt_d = cnt_q - 16'd1;
      end
      S_DONE: begin
        // A rejected request already pulsed done on entry; don't pulse twice.
        state_d = S_IDLE;
        ss_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = ~done_q;
        err_d   = ~done_q & echo_q;
        echo_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclock or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q <= S_IDLE;
      off_q   <= 16'd0;
      idx_q   <= '0;
      rem_q   <= 17'd0;
      cnt_q   <= 16'd0;
      div_q   <= 16'd0;
      bit_q   <= 4'd0;
      echo_q  <= 1'b0;
      sck_q   <= 1'b0;
      ss_q    <= 1'b1;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      echo_q  <= echo_d;
      sck_q   <= sck_d;
      ss_q    <= ss_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge sysclock or negedge sysreset_n) begin
    if (!sysreset_n) rx_q <= '0;
    else if (rx_we) rx_q[idx_q] <= cipo;
  end

  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign sck     = sck_q;
  assign ss      = ss_q;
  assign copi    = copi_q;

endmodule
